// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative share-parallel (Inv)MixColumns, one column per clock for every share.
// Rev 1.0 - initial release
`default_nettype none

module mix_columns_iter #(
  parameter int NSHARES = 2,
  parameter int COLS    = 4
) (
  input  logic                        ClkxCI,
  input  logic                        RstxBI,
  input  logic                        StartxSI,
  input  logic                        InvxSI,
  input  logic [NSHARES*COLS*32-1:0]  StatexDI,
  output logic                        ReadyxSO,
  output logic                        DonexSO,
  output logic [NSHARES*COLS*32-1:0]  StatexDO
);

  localparam int SW = COLS * 32;
  localparam int W  = NSHARES * SW;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul_9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] mul_b(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] mul_d(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] mul_e(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  // Row r uses bytes a[r], a[r+1], a[r+2], a[r+3] (mod 4) against the fixed coefficient row.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [31:0] res;
    logic [7:0]  a0, a1, a2, a3;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      a0 = col[r*8 +: 8];
      a1 = col[((r+1)%4)*8 +: 8];
      a2 = col[((r+2)%4)*8 +: 8];
      a3 = col[((r+3)%4)*8 +: 8];
      if (inv) res[r*8 +: 8] = mul_e(a0) ^ mul_b(a1) ^ mul_d(a2) ^ mul_9(a3);
      else     res[r*8 +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
    end
    return res;
  endfunction

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    work_q, work_d;
  logic [W-1:0]    out_q, out_d;
  logic            inv_q, inv_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic [W-1:0]    w_rot;

  // One column unit per share; the transformed column re-enters at the top so after COLS steps all columns are done in place.
  for (genvar s = 0; s < NSHARES; s++) begin : g_share
    logic [31:0] w_col_out;
    assign w_col_out = mix_col(work_q[s*SW +: 32], inv_q);
    if (COLS > 1) begin : g_rot
      assign w_rot[s*SW +: SW] = {w_col_out, work_q[s*SW+32 +: SW-32]};
    end else begin : g_single
      assign w_rot[s*SW +: SW] = w_col_out;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    inv_d   = inv_q;
    out_d   = out_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (StartxSI) begin
          state_d = BUSY;
          work_d  = StatexDI;
          inv_d   = InvxSI;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        work_d = w_rot;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST_COL) begin
          state_d = DONE;
          out_d   = w_rot;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d != BUSY);
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      inv_q   <= 1'b0;
      out_q   <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      inv_q   <= inv_d;
      out_q   <= out_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ReadyxSO = ready_q;
  assign DonexSO  = done_q;
  assign StatexDO = out_q;

endmodule

`default_nettype wire
